// File: rtl/image_pass_if.sv
// Handshake and image-buffer signals between the command decoder/buffer side and image_pass_ctrl.
interface image_pass_if;
  localparam int unsigned RAW = 7;
  localparam int unsigned WAW = 9;
  localparam int unsigned DW  = 3072;

  logic           start;
  logic           src_sel;
  logic           busy;
  logic           done;
  logic [RAW-1:0] raddr0;
  logic [RAW-1:0] raddr1;
  logic [RAW-1:0] raddr2;
  logic           re;
  logic           img_idx;
  logic [DW-1:0]  filt_data;
  logic [WAW-1:0] waddr;
  logic           we;
  logic [DW-1:0]  wdata;

  modport master (
    output start, src_sel, filt_data,
    input  busy, done, raddr0, raddr1, raddr2, re, img_idx, waddr, we, wdata
  );

  modport slave (
    input  start, src_sel, filt_data,
    output busy, done, raddr0, raddr1, raddr2, re, img_idx, waddr, we, wdata
  );
endinterface

// File: rtl/image_pass_ctrl.sv
// Full-frame 3x3 filter pass sequencer: clamped row windows, fixed-latency wait, row write-back.
// Optional IMG_INPLACE_DEFER_EN delays each write by one row so in-place passes on the recent image are safe.
module image_pass_ctrl #(
  parameter int unsigned ROWS     = 128,
  parameter int unsigned FILT_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  image_pass_if.slave  bus
);
  localparam int unsigned RW = 7;
  localparam int unsigned DW = 3072;
  localparam int unsigned CW = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(FILT_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
`ifdef IMG_INPLACE_DEFER_EN
    FLUSH,
`endif
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          img_idx_q, img_idx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          re_q, re_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [RW-1:0] raddr0_q, raddr0_d, raddr1_q, raddr1_d, raddr2_q, raddr2_d;
  logic [8:0]    waddr_q, waddr_d;

`ifdef IMG_INPLACE_DEFER_EN
  logic [DW-1:0] pend_q, pend_d;
`else
  logic src_sel_unused;
  assign src_sel_unused = bus.src_sel;
`endif

  // Next state, then outputs derived from the upcoming state so they are registered in-phase.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    wcnt_d    = wcnt_q;
    img_idx_d = img_idx_q;
    wdata_d   = wdata_q;
`ifdef IMG_INPLACE_DEFER_EN
    pend_d    = pend_q;
`endif
    re_d      = 1'b0;
    raddr0_d  = '0;
    raddr1_d  = '0;
    raddr2_d  = '0;
    we_d      = 1'b0;
    waddr_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef IMG_INPLACE_DEFER_EN
          img_idx_d = bus.src_sel;
`else
          img_idx_d = 1'b0;
`endif
          r_d     = '0;
          state_d = READ;
        end
      end
      READ: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == LAST_WAIT) begin
          state_d = WRITE;
`ifdef IMG_INPLACE_DEFER_EN
          if (img_idx_q) begin
            wdata_d = pend_q;
            pend_d  = bus.filt_data;
          end else
`endif
          wdata_d = bus.filt_data;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (r_q == LAST_ROW) begin
`ifdef IMG_INPLACE_DEFER_EN
          if (img_idx_q) begin
            wdata_d = pend_q;
            state_d = FLUSH;
          end else
`endif
          state_d = DONE;
        end else begin
          r_d     = r_q + 1'b1;
          state_d = READ;
        end
      end
`ifdef IMG_INPLACE_DEFER_EN
      FLUSH:   state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = !(state_d == IDLE || state_d == DONE);
    done_d = (state_d == DONE);

    if (state_d == READ) begin
      re_d     = 1'b1;
      raddr1_d = r_d;
      raddr0_d = (r_d == '0) ? '0 : r_d - 1'b1;
      raddr2_d = (r_d == LAST_ROW) ? r_d : r_d + 1'b1;
    end

    if (state_d == WRITE) begin
`ifdef IMG_INPLACE_DEFER_EN
      // Deferred slot writes the previous row; row 0's slot has no write.
      if (img_idx_d) begin
        we_d    = (r_d != '0);
        waddr_d = (r_d != '0) ? {2'b00, r_d - 1'b1} : '0;
      end else
`endif
      begin
        we_d    = 1'b1;
        waddr_d = {2'b00, r_d};
      end
    end

`ifdef IMG_INPLACE_DEFER_EN
    if (state_d == FLUSH) begin
      we_d    = 1'b1;
      waddr_d = {2'b00, r_d};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      wcnt_q    <= '0;
      img_idx_q <= 1'b0;
      wdata_q   <= '0;
`ifdef IMG_INPLACE_DEFER_EN
      pend_q    <= '0;
`endif
      re_q      <= 1'b0;
      raddr0_q  <= '0;
      raddr1_q  <= '0;
      raddr2_q  <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      wcnt_q    <= wcnt_d;
      img_idx_q <= img_idx_d;
      wdata_q   <= wdata_d;
`ifdef IMG_INPLACE_DEFER_EN
      pend_q    <= pend_d;
`endif
      re_q      <= re_d;
      raddr0_q  <= raddr0_d;
      raddr1_q  <= raddr1_d;
      raddr2_q  <= raddr2_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.re      = re_q;
  assign bus.raddr0  = raddr0_q;
  assign bus.raddr1  = raddr1_q;
  assign bus.raddr2  = raddr2_q;
  assign bus.we      = we_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.img_idx = img_idx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_image_pass_ctrl.sv
// Randomized bench for image_pass_ctrl against a per-cycle schedule computed from row timing arithmetic.
module tb_image_pass_ctrl;
  localparam int ROWS = 4;
  localparam int FL   = 2;
  localparam int NC   = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  image_pass_if b ();
  image_pass_if b1 ();
  assign b1.start     = b.start;
  assign b1.src_sel   = b.src_sel;
  assign b1.filt_data = b.filt_data;

  image_pass_ctrl #(.ROWS(ROWS), .FILT_LAT(FL)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(b));
  image_pass_ctrl #(.ROWS(1),    .FILT_LAT(FL)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int n_checks = 0;
  int n_errors = 0;

  bit         e_re[NC], e_we[NC], e_done[NC], e_busy[NC];
  logic [6:0] e_r0[NC], e_r1[NC], e_r2[NC];
  logic [8:0] e_wa[NC];
  int         e_wrow[NC], cap_row[NC];
  logic [31:0] val[ROWS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected schedule: READ of row r at 1+r*(FL+2), its write slot FL+1 later.
  task automatic build(input bit defer);
    int p, rd, wr, last;
    p = FL + 2;
    last = 0;
    for (int c = 0; c < NC; c++) begin
      e_re[c] = 0; e_we[c] = 0; e_done[c] = 0; e_busy[c] = 0;
      e_r0[c] = '0; e_r1[c] = '0; e_r2[c] = '0; e_wa[c] = '0;
      e_wrow[c] = 0; cap_row[c] = -1;
    end
    for (int r = 0; r < ROWS; r++) begin
      rd = 1 + r * p;
      wr = rd + FL + 1;
      e_re[rd] = 1;
      e_r0[rd] = 7'((r > 0) ? r - 1 : 0);
      e_r1[rd] = 7'(r);
      e_r2[rd] = 7'((r < ROWS - 1) ? r + 1 : ROWS - 1);
      cap_row[rd + FL] = r;
      if (!defer) begin
        e_we[wr] = 1; e_wa[wr] = 9'(r); e_wrow[wr] = r; last = wr;
      end else if (r > 0) begin
        e_we[wr] = 1; e_wa[wr] = 9'(r - 1); e_wrow[wr] = r - 1; last = wr;
      end
    end
    if (defer) begin
      last++;
      e_we[last] = 1; e_wa[last] = 9'(ROWS - 1); e_wrow[last] = ROWS - 1;
    end
    e_done[last + 1] = 1;
    for (int c = 1; c <= last; c++) e_busy[c] = 1;
  endtask

  task automatic check_idle(input string t);
    check({t, " re"},      64'(b.re), 64'd0);
    check({t, " we"},      64'(b.we), 64'd0);
    check({t, " done"},    64'(b.done), 64'd0);
    check({t, " busy"},    64'(b.busy), 64'd0);
    check({t, " raddr"},   64'({b.raddr0, b.raddr1, b.raddr2}), 64'd0);
    check({t, " waddr"},   64'(b.waddr), 64'd0);
    check({t, " img_idx"}, 64'(b.img_idx), 64'd0);
    check({t, " wdata"},   64'(|b.wdata), 64'd0);
  endtask

  task automatic run_pass(input int pass, input bit src, input int rst_at, input bit poke);
    bit defer;
    string t;
`ifdef IMG_INPLACE_DEFER_EN
    defer = src;
`else
    defer = 1'b0;
`endif
    build(defer);
    for (int r = 0; r < ROWS; r++) val[r] = $urandom();
    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;
      b.start   = (c == 0) || (poke && (c == 6 || e_done[c]));
      b.src_sel = (c == 0) ? src : 1'($urandom());
      b.filt_data = (cap_row[c] >= 0) ? {96{val[cap_row[c]]}} : {96{32'($urandom())}};
      if (rst_at >= 0 && c == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && c == rst_at + 2) rst_n = 1'b1;
      @(negedge clk);
      t = $sformatf("p%0d c%0d", pass, c);
      if (rst_at >= 0 && c >= rst_at) begin
        check_idle(t);
      end else begin
        check({t, " re"},     64'(b.re), 64'(e_re[c]));
        check({t, " raddr0"}, 64'(b.raddr0), 64'(e_r0[c]));
        check({t, " raddr1"}, 64'(b.raddr1), 64'(e_r1[c]));
        check({t, " raddr2"}, 64'(b.raddr2), 64'(e_r2[c]));
        check({t, " we"},     64'(b.we), 64'(e_we[c]));
        check({t, " waddr"},  64'(b.waddr), 64'(e_wa[c]));
        check({t, " done"},   64'(b.done), 64'(e_done[c]));
        check({t, " busy"},   64'(b.busy), 64'(e_busy[c]));
        if (c > 0) check({t, " img_idx"}, 64'(b.img_idx), 64'(defer));
        if (e_we[c]) begin
          check({t, " wdata_lo"},  64'(b.wdata[31:0]), 64'(val[e_wrow[c]]));
          check({t, " wdata_rep"}, 64'(b.wdata == {96{val[e_wrow[c]]}}), 64'd1);
        end
      end
      if (pass == 1) begin
        if (c == 1) begin
          check({t, " r1 re"},    64'(b1.re), 64'd1);
          check({t, " r1 raddr"}, 64'({b1.raddr0, b1.raddr1, b1.raddr2}), 64'd0);
        end
        if (c == 4) begin
          check({t, " r1 we"},    64'(b1.we), 64'd1);
          check({t, " r1 waddr"}, 64'(b1.waddr), 64'd0);
          check({t, " r1 wdata"}, 64'(b1.wdata == {96{val[0]}}), 64'd1);
        end
        if (c == 5) check({t, " r1 done"}, 64'(b1.done), 64'd1);
      end
    end
    b.start = 1'b0;
  endtask

  initial begin
    b.start = 1'b0;
    b.src_sel = 1'b0;
    b.filt_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_pass(1, 1'b0, -1, 1'b1);
    run_pass(2, 1'b1, -1, 1'b0);
    run_pass(3, 1'($urandom()), 6, 1'b0);
    run_pass(4, 1'b0, -1, 1'b0);
    for (int p = 5; p < 9; p++) run_pass(p, 1'($urandom()), -1, 1'($urandom()));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
